// File: rtl/nn_ctrl_pkg.sv
// Shared types and constants for the XOR training sequencer.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TR_SETTLE,
    ST_TR_WRITE,
    ST_TS_SETTLE,
    ST_TS_SCORE,
    ST_DONE
  } sched_state_t;

  // Prediction/expected-result encoding used by the datapath; 2'b11 is not produced
  typedef enum logic [1:0] {
    PRED_NONE = 2'b00,
    PRED_ZERO = 2'b01,
    PRED_ONE  = 2'b10
  } pred_t;

  localparam int NUM_SAMPLES = 4;

  typedef struct packed {
    logic busy;
    logic read_en;
    logic write_en;
    logic test_flag;
    logic done;
  } sched_out_t;

  // Strobe pattern presented while the FSM sits in a given state
  function automatic sched_out_t state_outs(input sched_state_t s);
    sched_out_t o;
    o = '0;
    case (s)
      ST_TR_SETTLE: begin o.busy = 1'b1; o.read_en = 1'b1; end
      ST_TR_WRITE:  begin o.busy = 1'b1; o.write_en = 1'b1; end
      ST_TS_SETTLE: begin o.busy = 1'b1; o.read_en = 1'b1; o.test_flag = 1'b1; end
      ST_TS_SCORE:  begin o.busy = 1'b1; o.test_flag = 1'b1; end
      ST_DONE:      begin o.busy = 1'b1; o.done = 1'b1; end
      default:      o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/nn_settle_timer.sv
// Loadable down-counter; tc is high when the count has reached zero.
// Latency: load takes effect on the next edge; tc is a decode of the count register.
// Backpressure: none; decrement stops at zero until reloaded.
module nn_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Reload has priority; otherwise count down and park at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !tc) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/nn_train_scheduler.sv
// Train/test sequencer for the 2-3-1 XOR datapath with start/busy/done handshake.
// Latency: 4*NUM_EPOCHS*(SETTLE_CYCLES+1) + 4*(SETTLE_CYCLES+1) + 1 cycles per run; all strobes registered.
// Backpressure: none; start ignored while busy, abort returns to idle on the next edge.
// Option NN_EARLY_STOP_EN: test pass after every epoch, stop early once all 4 samples score.
module nn_train_scheduler
  import nn_ctrl_pkg::*;
#(
  parameter int NUM_EPOCHS    = 1000,
  parameter int SETTLE_CYCLES = 2,
  parameter int EPOCH_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         predicted,
  input  logic [1:0]         expected,
  output logic               x_input,
  output logic               y_input,
  output logic               read_en,
  output logic               write_en,
  output logic               test_flag,
  output logic               busy,
  output logic               done,
  output logic [EPOCH_W-1:0] epoch_count,
  output logic [2:0]         correct_count
);

  localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TW-1:0]      SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [1:0]         LAST_IDX    = 2'(NUM_SAMPLES - 1);
  localparam logic [EPOCH_W-1:0] EPOCH_TGT   = EPOCH_W'(NUM_EPOCHS);
  localparam logic [EPOCH_W-1:0] EPOCH_MAX   = '1;

  sched_state_t       state;
  sched_out_t         outs;
  logic [1:0]         idx;
  logic               settle_load;
  logic               settle_dec;
  logic               settle_tc;
  logic               sample_ok;
  logic [EPOCH_W-1:0] epoch_inc;
  logic [2:0]         correct_inc;

  // Timer is preloaded in every non-settle state so it is ready on entry to a settle state
  always_comb begin
    settle_load = (state != ST_TR_SETTLE) && (state != ST_TS_SETTLE);
    settle_dec  = !settle_load;
  end

  nn_settle_timer #(.W(TW)) u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (settle_load),
    .dec      (settle_dec),
    .load_val (SETTLE_LOAD),
    .tc       (settle_tc)
  );

  // Scoring and saturating epoch increment feeding the FSM
  always_comb begin
    sample_ok   = (predicted == expected) && (predicted != PRED_NONE);
    epoch_inc   = (epoch_count == EPOCH_MAX) ? epoch_count : epoch_count + 1'b1;
    correct_inc = correct_count + {2'b00, sample_ok};
  end

  // Run sequencing: state, sample index, counters and registered strobes advance together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      outs          <= '0;
      idx           <= '0;
      epoch_count   <= '0;
      correct_count <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
      outs  <= state_outs(ST_IDLE);
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_TR_SETTLE;
            outs          <= state_outs(ST_TR_SETTLE);
            idx           <= '0;
            epoch_count   <= '0;
            correct_count <= '0;
          end
        end
        ST_TR_SETTLE: begin
          if (settle_tc) begin
            state <= ST_TR_WRITE;
            outs  <= state_outs(ST_TR_WRITE);
          end
        end
        ST_TR_WRITE: begin
          if (idx != LAST_IDX) begin
            idx   <= idx + 1'b1;
            state <= ST_TR_SETTLE;
            outs  <= state_outs(ST_TR_SETTLE);
          end else begin
            idx         <= '0;
            epoch_count <= epoch_inc;
`ifdef NN_EARLY_STOP_EN
            state <= ST_TS_SETTLE;
            outs  <= state_outs(ST_TS_SETTLE);
`else
            if (epoch_inc == EPOCH_TGT) begin
              state <= ST_TS_SETTLE;
              outs  <= state_outs(ST_TS_SETTLE);
            end else begin
              state <= ST_TR_SETTLE;
              outs  <= state_outs(ST_TR_SETTLE);
            end
`endif
          end
        end
        ST_TS_SETTLE: begin
          if (settle_tc) begin
            state <= ST_TS_SCORE;
            outs  <= state_outs(ST_TS_SCORE);
          end
        end
        ST_TS_SCORE: begin
          correct_count <= correct_inc;
          if (idx != LAST_IDX) begin
            idx   <= idx + 1'b1;
            state <= ST_TS_SETTLE;
            outs  <= state_outs(ST_TS_SETTLE);
          end else begin
            idx <= '0;
`ifdef NN_EARLY_STOP_EN
            if ((correct_inc == 3'(NUM_SAMPLES)) || (epoch_count >= EPOCH_TGT)) begin
              state <= ST_DONE;
              outs  <= state_outs(ST_DONE);
            end else begin
              correct_count <= '0;
              state         <= ST_TR_SETTLE;
              outs          <= state_outs(ST_TR_SETTLE);
            end
`else
            state <= ST_DONE;
            outs  <= state_outs(ST_DONE);
`endif
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          outs  <= state_outs(ST_IDLE);
        end
        default: begin
          state <= ST_IDLE;
          outs  <= state_outs(ST_IDLE);
        end
      endcase
    end
  end

  assign x_input   = idx[1];
  assign y_input   = idx[0];
  assign busy      = outs.busy;
  assign read_en   = outs.read_en;
  assign write_en  = outs.write_en;
  assign test_flag = outs.test_flag;
  assign done      = outs.done;

endmodule

// File: tb/tb_nn_train_scheduler.sv
// Scoreboard bench: each run's expected per-cycle strobes come from a phase timeline built
// from the sequencing rules; a negedge monitor pops and compares them and the final counts.
module tb_nn_train_scheduler;

  localparam int NE = 3;
  localparam int S  = 2;
  localparam int EW = 16;

  localparam int K_TRS = 0;
  localparam int K_TRW = 1;
  localparam int K_TSS = 2;
  localparam int K_TSC = 3;
  localparam int K_DN  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    predicted;
  logic [1:0]    expected;
  logic          x_input, y_input, read_en, write_en, test_flag, busy, done;
  logic [EW-1:0] epoch_count;
  logic [2:0]    correct_count;

  nn_train_scheduler #(.NUM_EPOCHS(NE), .SETTLE_CYCLES(S), .EPOCH_W(EW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .predicted     (predicted),
    .expected      (expected),
    .x_input       (x_input),
    .y_input       (y_input),
    .read_en       (read_en),
    .write_en      (write_en),
    .test_flag     (test_flag),
    .busy          (busy),
    .done          (done),
    .epoch_count   (epoch_count),
    .correct_count (correct_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] val;
    logic [5:0] mask;
  } cyc_t;

  typedef struct {
    int cycles;
    int epochs;
    int correct;
  } end_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   runs_checked = 0;
  logic [1:0] pred_tab [4];
  logic [1:0] exp_tab  [4];
  int   tl_kind [$];
  int   tl_idx  [$];
  cyc_t cyc_q [$];
  end_t end_q [$];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Prediction unit stand-in: answer for whichever sample the DUT is presenting
  always @(negedge clk) begin
    predicted = pred_tab[{x_input, y_input}];
    expected  = exp_tab[{x_input, y_input}];
  end

  function automatic bit score_ok(input int i);
    return (pred_tab[i] == exp_tab[i]) && (pred_tab[i] != 2'b00);
  endfunction

  function automatic int pass_score();
    int n = 0;
    for (int i = 0; i < 4; i++) if (score_ok(i)) n++;
    return n;
  endfunction

  function automatic void push_tl(input int k, input int i);
    tl_kind.push_back(k);
    tl_idx.push_back(i);
  endfunction

  function automatic void push_pass();
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < S; s++) push_tl(K_TSS, i);
      push_tl(K_TSC, i);
    end
  endfunction

  // Phase-by-phase timeline of one uninterrupted run
  function automatic void build_timeline();
    tl_kind.delete();
    tl_idx.delete();
    for (int e = 1; e <= NE; e++) begin
      for (int i = 0; i < 4; i++) begin
        for (int s = 0; s < S; s++) push_tl(K_TRS, i);
        push_tl(K_TRW, i);
      end
`ifdef NN_EARLY_STOP_EN
      push_pass();
      if (pass_score() == 4 || e == NE) begin
        push_tl(K_DN, 0);
        return;
      end
`else
      if (e == NE) begin
        push_pass();
        push_tl(K_DN, 0);
      end
`endif
    end
  endfunction

  // mode 0: full run (with a stray start mid-run), 1: abort during cycle a, 2: async reset in cycle a
  task automatic run_case(input int mode, input int a);
    int n_vis, n_commit, ep, cc, len, guard, target, c;
    cyc_t e;
    end_t r;
    build_timeline();
    len = tl_kind.size();
    ep = 0;
    cc = 0;
    if (mode == 0) begin n_vis = len; n_commit = len; end
    else if (mode == 1) begin n_vis = a + 1; n_commit = a; end
    else begin n_vis = a; n_commit = 0; end
    for (int j = 0; j < n_commit; j++) begin
      if (tl_kind[j] == K_TRW && tl_idx[j] == 3) ep++;
      if (tl_kind[j] == K_TSC) begin
        if (score_ok(tl_idx[j])) cc++;
`ifdef NN_EARLY_STOP_EN
        if (tl_idx[j] == 3 && j + 1 < len && tl_kind[j+1] == K_TRS) cc = 0;
`endif
      end
    end
    for (int j = 0; j < n_vis; j++) begin
      int k;
      int i;
      k = tl_kind[j];
      i = tl_idx[j];
      e.val  = {1'(k == K_TRS || k == K_TSS), 1'(k == K_TRW), 1'(k == K_TSS || k == K_TSC),
                1'(k == K_DN), 2'(i)};
      e.mask = 6'b111111;
      if (k == K_TSC) e.mask[5] = 1'b0;
      if (k == K_DN)  e.mask[1:0] = 2'b00;
      cyc_q.push_back(e);
    end
    r.cycles = n_vis;
    r.epochs = ep;
    r.correct = cc;
    end_q.push_back(r);
    target = runs_checked + 1;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (mode == 0) begin
      c = $urandom_range(1, len - 3);
      repeat (c) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end else if (mode == 1) begin
      repeat (a) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end else begin
      repeat (a) @(posedge clk);
      #2;
      check("write_en_before_reset", int'(write_en), 1);
      reset = 1'b0;
      #1;
      check("write_en_after_reset", int'(write_en), 0);
      check("outputs_after_reset",
            int'({x_input, y_input, read_en, test_flag, busy, done}), 0);
      check("epoch_after_reset", int'(epoch_count), 0);
    end

    guard = 0;
    while (runs_checked < target && guard < len + 50) begin
      @(negedge clk);
      guard++;
    end
    check("run_completed_in_time", int'(runs_checked >= target), 1);
    if (mode == 2) begin
      @(negedge clk);
      reset = 1'b1;
    end
    if (mode == 0) begin
      repeat (3) @(negedge clk);
      check("epoch_hold", int'(epoch_count), ep);
      check("correct_hold", int'(correct_count), cc);
    end
  endtask

  // Monitor: pop one expected strobe pattern per busy cycle, final counts when busy drops
  int ncyc = 0;
  bit running = 1'b0;
  always @(negedge clk) begin
    cyc_t e;
    end_t r;
    logic [5:0] obs;
    obs = {read_en, write_en, test_flag, done, x_input, y_input};
    if (busy) begin
      running = 1'b1;
      if (cyc_q.size() == 0) begin
        check("cycle_queue_underrun", 1, 0);
      end else begin
        e = cyc_q.pop_front();
        check($sformatf("cycle%0d_rd_wr_test_done_x_y", ncyc),
              int'(obs & e.mask), int'(e.val & e.mask));
      end
      ncyc++;
    end else if (running) begin
      running = 1'b0;
      if (end_q.size() == 0) begin
        check("end_queue_underrun", 1, 0);
      end else begin
        r = end_q.pop_front();
        check("run_cycles", ncyc, r.cycles);
        check("epoch_count", int'(epoch_count), r.epochs);
        check("correct_count", int'(correct_count), r.correct);
        check("cycles_left_unseen", cyc_q.size(), 0);
      end
      cyc_q.delete();
      ncyc = 0;
      runs_checked++;
    end else begin
      check("idle_strobes", int'(obs[5:2]), 0);
    end
  end

  function automatic void set_all_correct();
    for (int i = 0; i < 4; i++) begin
      exp_tab[i]  = (i == 1 || i == 2) ? 2'b10 : 2'b01;
      pred_tab[i] = exp_tab[i];
    end
  endfunction

  initial begin
    set_all_correct();
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_epoch", int'(epoch_count), 0);
    check("reset_correct", int'(correct_count), 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_xy", int'({x_input, y_input}), 0);

    run_case(0, 0);                       // all samples correct
    pred_tab[1] = ~exp_tab[1];
    pred_tab[3] = ~exp_tab[3];
    run_case(0, 0);                       // wrong on idx 1 and 3
    for (int i = 0; i < 4; i++) pred_tab[i] = 2'b00;
    run_case(0, 0);                       // all predictions invalid
    set_all_correct();
    run_case(1, 20);                      // abort in cycle 20
    run_case(0, 0);                       // clean run after abort
    run_case(2, (S + 1) * 5 + S);         // async reset inside a write cycle

    for (int n = 0; n < 10; n++) begin
      int m;
      int len;
      for (int i = 0; i < 4; i++) begin
        exp_tab[i]  = 2'($urandom_range(0, 2));
        pred_tab[i] = ($urandom_range(0, 1) == 1) ? exp_tab[i] : 2'($urandom_range(0, 2));
      end
      build_timeline();
      len = tl_kind.size();
      m = $urandom_range(0, 2);
      if (m == 1) run_case(1, $urandom_range(0, len - 1));
      else if (m == 2) run_case(2, (S + 1) * $urandom_range(0, 4 * NE - 1) + S);
      else run_case(0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nn_train_scheduler.md
Name: nn_train_scheduler

Overview:
Sequencing controller for the 2-3-1 XOR network datapath (NeuronRAM banks plus the FP/BP/OP neuron chain). It drives the sample inputs, the NeuronRAM read/write phases and the test flag. It runs NUM_EPOCHS training epochs over the four XOR samples, then one scored test pass. It replaces the free-running 3-bit phase counter with an explicit start/busy/done handshake and reports epoch and accuracy results.

Parameters:
NUM_EPOCHS, 1000, training epochs before the test pass (>=1)
SETTLE_CYCLES, 2, cycles the inputs are held with read_en=1 before each write or score (>=1)
EPOCH_W, 16, width of epoch_count (must hold NUM_EPOCHS)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a run; sampled only in IDLE
abort  in  1  synchronous abort to IDLE from any state
predicted  in  2  prediction unit output (2'b10=1, 2'b01=0, 2'b00=invalid)
expected  in  2  expected-result encoding, same format
x_input  out  1  sample bit x to datapath
y_input  out  1  sample bit y to datapath
read_en  out  1  NeuronRAM read phase
write_en  out  1  NeuronRAM write (parameter update) strobe
test_flag  out  1  datapath test mode
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a run completes
epoch_count  out  EPOCH_W  completed training epochs
correct_count  out  3  correctly predicted samples in the last test pass (0..4)

Behaviour:
- Reset (reset=0, async): state IDLE; idx=0, settle counter=0; all outputs 0; epoch_count=0; correct_count=0.
- Sample index idx[1:0]: x_input=idx[1], y_input=idx[0]. Order is 00,01,10,11.
- States: IDLE, TR_SETTLE, TR_WRITE, TS_SETTLE, TS_SCORE, DONE.
- IDLE: read_en=write_en=test_flag=0. start=1 -> TR_SETTLE with idx=0, epoch_count=0, correct_count=0.
- TR_SETTLE: read_en=1 for SETTLE_CYCLES cycles, then -> TR_WRITE.
- TR_WRITE: exactly one cycle with write_en=1 and read_en=0.
  - If idx<3: idx++ and -> TR_SETTLE.
  - If idx==3: idx=0 and epoch_count++. If the new epoch_count==NUM_EPOCHS -> TS_SETTLE, else -> TR_SETTLE.
- TS_SETTLE: test_flag=1, read_en=1, write_en=0 for SETTLE_CYCLES cycles, then -> TS_SCORE.
- TS_SCORE: one cycle, test_flag=1. The sample is correct when predicted==expected and predicted!=2'b00; correct_count++ when correct.
  - idx<3: idx++ and -> TS_SETTLE.
  - idx==3: -> DONE.
- DONE: done=1 for one cycle, then -> IDLE. epoch_count and correct_count hold until the next start.
- write_en and test_flag are never high together. write_en is never high outside TR_WRITE.
- Latency per run: 4*NUM_EPOCHS*(SETTLE_CYCLES+1) training cycles + 4*(SETTLE_CYCLES+1) test cycles + 1 DONE cycle.
- start while busy: ignored.
- abort: -> IDLE next edge; takes priority over all transitions including start. done is not pulsed. Counts freeze at their current values.
- Async reset mid-run: immediate return to the reset state. No partial write strobe may be produced; write_en is a registered output.
- epoch_count saturates at its maximum value and never wraps.

Optional Feature:
Macro NN_EARLY_STOP_EN.
- Defined: after every training epoch (TR_WRITE with idx==3), run a full test pass (TS_SETTLE/TS_SCORE over 4 samples).
  - correct_count==4 -> DONE (early stop).
  - Otherwise, if epoch_count<NUM_EPOCHS, reset correct_count to 0 and resume TR_SETTLE at idx=0.
  - Once epoch_count reaches NUM_EPOCHS, the last test pass result is final.
- Undefined: single test pass after NUM_EPOCHS only, as above.

Decomposition:
- Package nn_ctrl_pkg holds:
  - state enum sched_state_t;
  - PRED_ONE=2'b10, PRED_ZERO=2'b01, PRED_NONE=2'b00;
  - NUM_SAMPLES=4.
- One natural sub-module, nn_settle_timer: loadable down-counter with a terminal-count flag, used by both settle states.

Test Plan:
- Reset/idle: hold reset=0 then release with no start -> all outputs 0 and busy=0 indefinitely.
- Full run (NUM_EPOCHS=3, SETTLE_CYCLES=2), predicted==expected forced:
  - exactly 12 write_en pulses;
  - x/y sequence 00,01,10,11 repeated;
  - done pulses 49 cycles after the start edge;
  - epoch_count=3, correct_count=4.
- Scoring: same run with predicted wrong on idx 1 and idx 3 -> correct_count=2. predicted=2'b00 on all samples -> correct_count=0.
- Abort: assert abort at cycle 20 of a run -> IDLE next cycle, busy=0, no done pulse, epoch_count=1. Then start again -> counts cleared and a full run completes.
- Async reset mid-TR_WRITE: reset falls between edges -> write_en drops immediately with no glitch pulse, and all outputs return to 0. start during busy -> ignored, run length unchanged.
- NN_EARLY_STOP_EN, NUM_EPOCHS=5, predicted correct from epoch 2 -> done after epoch 2's test pass with epoch_count=2 and correct_count=4.
